shifter_arbiter: RTL and testbench

- Shares one 32-bit barrel shifter (combinational Shifter datapath, funct/a/N -> R) between two requesters.
- Round-robin arbitration; valid/ready handshake on each request and response channel.
- Operands and result are registered, so the shifter sits between two flop stages.
- Sits between the two execution clients (e.g. ALU issue and address generation) and the single shared Shifter instance it contains.

---
 rtl/shifter_arbiter.sv | 145 ++++++++++++++
 tb/tb_shifter_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_arbiter.sv
// shifter_arbiter: shares one 32-bit barrel shifter between two requesters.
//
// Each request is accepted with valid/ready, and requests are arbitrated round-robin.
// The operands are registered on the accept edge. The shifter result is registered
// one cycle later. The result is then held on rsp_data until the owner's response
// channel consumes it.
//
// Parameters:
//   FIRST_GRANT  requester that wins the first simultaneous-request tie after reset.
//
// Ports:
//   clk, reset               rising-edge clock, synchronous active-high reset
//   reqX_valid / reqX_ready  request handshake; ready is combinational (IDLE only)
//   reqX_funct, reqX_a,      shift type (00 LSL, 10 LSR, 11 ASR, 01 pass),
//   reqX_n                   operand, shift amount
//   rspX_valid / rspX_ready  response handshake; only the owner's valid is raised
//   rsp_data                 shared result bus, meaningful while a rspX_valid is high
//   busy                     high in any state other than IDLE
//
// Optional feature macro: SHIFTER_ARB_BACK2BACK_EN.
// When this macro is defined, a new request may be accepted in the same cycle
// that the current response is consumed. This gives one operation every 2 cycles.
module shifter_arbiter #(
    parameter int unsigned FIRST_GRANT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_funct,
    input  logic [31:0] req0_a,
    input  logic [4:0]  req0_n,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_funct,
    input  logic [31:0] req1_a,
    input  logic [4:0]  req1_n,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_data,
    output logic        busy
);

    localparam int unsigned DW = 32;
    localparam int unsigned NW = 5;
    localparam int unsigned FW = 2;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state, state_nxt;
    logic            owner;
    logic            last_grant;
    logic [FW-1:0]   op_funct;
    logic [DW-1:0]   op_a;
    logic [NW-1:0]   op_n;
    logic [DW-1:0]   shift_res;
    logic            accept_ok;
    logic            grant0, grant1;
    logic            rsp_done;

    // Shared shifter between the operand and result flops
    always_comb begin
        shift_res = op_a;
        case (op_funct)
            2'b00:   shift_res = op_a << op_n;
            2'b10:   shift_res = op_a >> op_n;
            2'b11:   shift_res = DW'($signed(op_a) >>> op_n);
            default: shift_res = op_a;
        endcase
    end

    // Next state, round-robin grant and response completion
    always_comb begin
        state_nxt = state;
        accept_ok = 1'b0;
        grant0    = 1'b0;
        grant1    = 1'b0;
        rsp_done  = owner ? rsp1_ready : rsp0_ready;
        case (state)
            IDLE: accept_ok = 1'b1;
            EXEC: state_nxt = RESP;
            RESP: begin
                if (rsp_done) begin
                    state_nxt = IDLE;
`ifdef SHIFTER_ARB_BACK2BACK_EN
                    accept_ok = 1'b1;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
        // On a tie the requester that was not granted last wins
        grant0 = accept_ok && req0_valid && (!req1_valid || last_grant);
        grant1 = accept_ok && req1_valid && (!req0_valid || !last_grant);
        if (grant0 || grant1) begin
            state_nxt = EXEC;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = (state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture, result register and response valids
    always_ff @(posedge clk) begin
        if (reset) begin
            owner      <= 1'b0;
            last_grant <= (FIRST_GRANT == 0) ? 1'b1 : 1'b0;
            op_funct   <= '0;
            op_a       <= '0;
            op_n       <= '0;
            rsp_data   <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
        end else begin
            if (state == EXEC) begin
                rsp_data   <= shift_res;
                rsp0_valid <= !owner;
                rsp1_valid <= owner;
            end else if (state == RESP && rsp_done) begin
                rsp0_valid <= 1'b0;
                rsp1_valid <= 1'b0;
            end
            if (grant0 || grant1) begin
                owner      <= grant1;
                last_grant <= grant1;
                op_funct   <= grant1 ? req1_funct : req0_funct;
                op_a       <= grant1 ? req1_a     : req0_a;
                op_n       <= grant1 ? req1_n     : req0_n;
            end
        end
    end

endmodule

// File: tb/tb_shifter_arbiter.sv
// tb_shifter_arbiter: scoreboard bench for shifter_arbiter.
// The bench pushes the expected results when an accept is observed.
// It pops and compares them when the owner's response is consumed.
// The build honours the macro SHIFTER_ARB_BACK2BACK_EN.
module tb_shifter_arbiter;

`ifdef SHIFTER_ARB_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif
    localparam int unsigned FIRST_GRANT = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [1:0]  req0_funct, req1_funct;
    logic [31:0] req0_a, req1_a, rsp_data;
    logic [4:0]  req0_n, req1_n;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    shifter_arbiter #(.FIRST_GRANT(FIRST_GRANT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_funct(req0_funct),
        .req0_a(req0_a), .req0_n(req0_n), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_funct(req1_funct),
        .req1_a(req1_a), .req1_n(req1_n), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference shifter; ASR is built bit by bit, independent of >>>
    function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a, input logic [4:0] n);
        logic [31:0] r;
        case (f)
            2'b00: r = a << n;
            2'b10: r = a >> n;
            2'b11: begin
                r = a;
                for (int i = 0; i < int'(n); i++) r = {a[31], r[31:1]};
            end
            default: r = a;
        endcase
        return r;
    endfunction

    // Monitor and scoreboard, sampled on the falling edge
    logic [32:0] sb[$];
    logic [32:0] e;
    logic        lg = 1'b1;
    logic        in_rsp = 1'b0;
    logic        can, e0, e1;
    logic [31:0] held;
    int          cyc = 0;
    int          acc_cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            sb.delete();
            lg     = (FIRST_GRANT == 0);
            in_rsp = 1'b0;
        end else begin
            can = !busy || (B2B && ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)));
            e0  = can && req0_valid && (!req1_valid || lg);
            e1  = can && req1_valid && (!req0_valid || !lg);
            if (req0_valid || req1_valid || req0_ready || req1_ready)
                check_eq("grant", 32'({req0_ready, req1_ready}), 32'({e0, e1}));
            if (rsp0_valid || rsp1_valid) begin
                check_eq("rsp_onehot", 32'(rsp0_valid & rsp1_valid), 32'd0);
                if (!in_rsp) begin
                    in_rsp = 1'b1;
                    held   = rsp_data;
                    // The response appears two cycles after the accept cycle
                    check_eq("latency", 32'(cyc - acc_cyc), 32'd2);
                end else begin
                    check_eq("rsp_hold", rsp_data, held);
                end
                if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                    in_rsp = 1'b0;
                    if (sb.size() == 0) begin
                        check_eq("spurious_rsp", 32'(rsp0_valid | rsp1_valid), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check_eq("rsp_id", 32'(rsp1_valid), 32'(e[32]));
                        check_eq("rsp_data", rsp_data, e[31:0]);
                    end
                end
            end
            if (req0_valid && req0_ready) begin
                sb.push_back({1'b0, model(req0_funct, req0_a, req0_n)});
                acc_cyc = cyc;
                lg = 1'b0;
            end
            if (req1_valid && req1_ready) begin
                sb.push_back({1'b1, model(req1_funct, req1_a, req1_n)});
                acc_cyc = cyc;
                lg = 1'b1;
            end
        end
    end

    // Present one request and return just after its accept edge
    task automatic do_op(input bit id, input logic [1:0] f, input logic [31:0] a, input logic [4:0] n);
        bit got = 1'b0;
        @(posedge clk); #1;
        if (id) begin req1_valid = 1'b1; req1_funct = f; req1_a = a; req1_n = n; end
        else    begin req0_valid = 1'b1; req0_funct = f; req0_a = a; req0_n = n; end
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = id ? req1_ready : req0_ready;
        end
        check_eq("accept_timeout", 32'(got), 32'd1);
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            done = !busy && !rsp0_valid && !rsp1_valid && (sb.size() == 0);
        end
        check_eq("idle_timeout", 32'(done), 32'd1);
    endtask

    // Single directed op, checked against a literal expected result
    task automatic run_op(input string tag, input bit id, input logic [1:0] f,
                          input logic [31:0] a, input logic [4:0] n, input logic [31:0] exp);
        bit got = 1'b0;
        do_op(id, f, a, n);
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = id ? rsp1_valid : rsp0_valid;
        end
        check_eq({tag, "_valid"}, 32'(got), 32'd1);
        check_eq({tag, "_other"}, 32'(id ? rsp0_valid : rsp1_valid), 32'd0);
        check_eq(tag, rsp_data, exp);
        wait_idle();
    endtask

    initial begin
        bit g;
        bit got;
        reset = 1'b1;
        req0_valid = 1'b0; req0_funct = '0; req0_a = '0; req0_n = '0; rsp0_ready = 1'b1;
        req1_valid = 1'b0; req1_funct = '0; req1_a = '0; req1_n = '0; rsp1_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        check_eq("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        check_eq("rst_rsp_data", rsp_data, 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Both requesters held valid: grants alternate starting with FIRST_GRANT
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_funct = 2'b00; req0_a = 32'h0000_0001; req0_n = 5'd3;
        req1_valid = 1'b1; req1_funct = 2'b10; req1_a = 32'h0000_0100; req1_n = 5'd4;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                got = req0_ready || req1_ready;
            end
            check_eq("alt_accept", 32'(got), 32'd1);
            check_eq("alt_onehot", 32'(req0_ready & req1_ready), 32'd0);
            g = req1_ready;
            check_eq("alt_grant", 32'(g), 32'(k % 2));
            @(posedge clk); #1;
            if (k == 3) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end else if (g) begin
                req1_funct = 2'($urandom_range(0, 3)); req1_a = $urandom; req1_n = 5'($urandom_range(0, 31));
            end else begin
                req0_funct = 2'($urandom_range(0, 3)); req0_a = $urandom; req0_n = 5'($urandom_range(0, 31));
            end
        end
        wait_idle();

        // Directed arithmetic cases
        run_op("lsl",      1'b0, 2'b00, 32'h000F_7279, 5'd4,  32'h00F7_2790);
        run_op("lsr",      1'b1, 2'b10, 32'hF000_0000, 5'd28, 32'h0000_000F);
        run_op("asr_neg",  1'b1, 2'b11, 32'h8000_0000, 5'd4,  32'hF800_0000);
        run_op("asr_pos31",1'b1, 2'b11, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000);
        run_op("asr_neg31",1'b0, 2'b11, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
        run_op("pass",     1'b0, 2'b01, 32'h1234_5678, 5'd17, 32'h1234_5678);
        run_op("asr_n0",   1'b1, 2'b11, 32'h8000_0001, 5'd0,  32'h8000_0001);
        run_op("lsl_n0",   1'b0, 2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);

        // Backpressure on requester 0 while requester 1 waits
        rsp0_ready = 1'b0;
        do_op(1'b0, 2'b00, 32'hA5A5_0001, 5'd3);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = rsp0_valid;
        end
        check_eq("bp_valid", 32'(got), 32'd1);
        req1_valid = 1'b1; req1_funct = 2'b10; req1_a = 32'h8000_0000; req1_n = 5'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_busy", 32'(busy), 32'd1);
            check_eq("bp_req1_ready", 32'(req1_ready), 32'd0);
            check_eq("bp_data", rsp_data, 32'h2D28_0008);
        end
        @(posedge clk); #1 rsp0_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_release_same", 32'(req1_ready), 32'(B2B));
        if (!B2B) begin
            @(negedge clk);
            check_eq("bp_release_next", 32'(req1_ready), 32'd1);
        end
        @(posedge clk); #1 req1_valid = 1'b0;
        wait_idle();

        // Reset while the operation is in EXEC: it must vanish
        do_op(1'b0, 2'b11, 32'hC000_0000, 5'd2);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_eq("midrst_rsp0", 32'(rsp0_valid), 32'd0);
        check_eq("midrst_rsp1", 32'(rsp1_valid), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_data", rsp_data, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("midrst_no_rsp", 32'(rsp0_valid | rsp1_valid), 32'd0);
        end

        // Random ops with random response stalls
        for (int k = 0; k < 30; k++) begin
            rsp0_ready = 1'($urandom_range(0, 1));
            rsp1_ready = 1'($urandom_range(0, 1));
            do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)));
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
            wait_idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
